// File: rtl/pdh_cmd_engine.sv
// Strobed command engine for the PDH core: LEDs, held DAC codes, ADC readback and block averaging.
// Define PDH_RAMP_EN to add the per-channel DAC ramp generator (cmds 3 and 5).
module pdh_cmd_engine #(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int DAC_DATA_WIDTH = 14,
    parameter int AVG_LOG2       = 4,
    parameter int RAMP_DIV_LOG2  = 8
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic [31:0]               cmd_word_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_a_i,
    input  logic [ADC_DATA_WIDTH-1:0] adc_b_i,
    output logic [7:0]                led_o,
    output logic [DAC_DATA_WIDTH-1:0] dac_a_o,
    output logic [DAC_DATA_WIDTH-1:0] dac_b_o,
    output logic [1:0]                dac_wrt_o,
    output logic                      busy_o,
    output logic [31:0]               status_o
);
    localparam int ADC_W = ADC_DATA_WIDTH;
    localparam int DAC_W = DAC_DATA_WIDTH;
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};

    localparam logic [3:0] CMD_SET_LED = 4'd1;
    localparam logic [3:0] CMD_SET_DAC = 4'd2;
    localparam logic [3:0] CMD_GET_ADC = 4'd4;
    localparam logic [3:0] CMD_AVG_ADC = 4'd6;
`ifdef PDH_RAMP_EN
    localparam logic [3:0] CMD_SET_RAMP_STEP = 4'd3;
    localparam logic [3:0] CMD_SET_RAMP_EN   = 4'd5;
`endif

    typedef enum logic [1:0] {AVG_IDLE, AVG_ACCUM, AVG_DONE} avg_state_t;

    logic [30:0] cmd_word_reg;
    logic        strobe_prev_reg;
    logic        strobe_edge;
    logic [3:0]  cmd;
    logic [25:0] data;
    logic        do_led, do_dac, do_avg;
    logic        unused_bits;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cmd_word_reg    <= '0;
            strobe_prev_reg <= 1'b0;
        end else begin
            cmd_word_reg    <= cmd_word_i[30:0];
            strobe_prev_reg <= cmd_word_reg[30];
        end
    end

    // Exactly one action per rising edge of the registered strobe.
    assign strobe_edge = cmd_word_reg[30] & ~strobe_prev_reg;
    assign cmd         = cmd_word_reg[29:26];
    assign data        = cmd_word_reg[25:0];
    assign do_led      = strobe_edge && (cmd == CMD_SET_LED);
    assign do_dac      = strobe_edge && (cmd == CMD_SET_DAC);
    assign do_avg      = strobe_edge && (cmd == CMD_AVG_ADC);
    assign unused_bits = ^{cmd_word_i[31], data[25:15]};

    logic [7:0] led_reg;
    always_ff @(posedge clk) begin
        if (rst_i)       led_reg <= '0;
        else if (do_led) led_reg <= data[7:0];
    end

    logic [1:0][ADC_W-1:0] adc_reg;
    always_ff @(posedge clk) begin
        if (rst_i) adc_reg <= '0;
        else       adc_reg <= {adc_b_i, adc_a_i};
    end

    avg_state_t            avg_state_reg, avg_state_next;
    logic [AVG_LOG2-1:0]   cnt_reg, cnt_next;
    logic                  acc_clear, acc_add, avg_load;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            avg_state_reg <= AVG_IDLE;
            cnt_reg       <= '0;
        end else begin
            avg_state_reg <= avg_state_next;
            cnt_reg       <= cnt_next;
        end
    end

    // Strobes arriving in ACCUM are dropped; IDLE and DONE both restart a fresh block.
    always_comb begin
        avg_state_next = avg_state_reg;
        cnt_next       = cnt_reg;
        acc_clear      = 1'b0;
        acc_add        = 1'b0;
        avg_load       = 1'b0;
        case (avg_state_reg)
            AVG_ACCUM: begin
                acc_add  = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == '1) begin
                    avg_load       = 1'b1;
                    avg_state_next = AVG_DONE;
                end
            end
            default: begin
                if (do_avg) begin
                    acc_clear      = 1'b1;
                    cnt_next       = '0;
                    avg_state_next = AVG_ACCUM;
                end
            end
        endcase
    end

    assign busy_o = (avg_state_reg == AVG_ACCUM);

`ifdef PDH_RAMP_EN
    localparam int PW = (RAMP_DIV_LOG2 > 0) ? RAMP_DIV_LOG2 : 1;
    localparam int RW = ((DAC_W > 14) ? DAC_W : 14) + 1;
    localparam logic [DAC_W-1:0] DAC_MAX = '1;

    logic          do_step, do_ramp_en, ramp_tick;
    logic [PW-1:0] presc_reg;
    logic [1:0][13:0] step_code;
    logic [1:0]    en_bits, down_bits;

    assign do_step    = strobe_edge && (cmd == CMD_SET_RAMP_STEP);
    assign do_ramp_en = strobe_edge && (cmd == CMD_SET_RAMP_EN);

    always_ff @(posedge clk) begin
        if (rst_i || do_ramp_en) presc_reg <= '0;
        else                     presc_reg <= presc_reg + 1'b1;
    end
    assign ramp_tick = (RAMP_DIV_LOG2 == 0) ? 1'b1 : (presc_reg == '1);
`endif

    logic [1:0][DAC_W-1:0] dac_code;
    logic [1:0]            wrt_bits;
    logic [1:0][13:0]      dac_pad, adc_pad, avg_pad;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [ACC_W-1:0] acc_reg, sample_ext, acc_sum, acc_shift;
            logic [ADC_W-1:0]        avg_reg;
            logic [DAC_W-1:0]        dac_reg;
            logic                    wrt_reg;
            logic                    set_hit;

            assign sample_ext = {{AVG_LOG2{adc_reg[gi][ADC_W-1]}}, adc_reg[gi]};
            assign acc_sum    = acc_reg + sample_ext;
            assign acc_shift  = acc_sum >>> AVG_LOG2;

            always_ff @(posedge clk) begin
                if (rst_i) begin
                    acc_reg <= '0;
                    avg_reg <= '0;
                end else begin
                    if (acc_clear)    acc_reg <= '0;
                    else if (acc_add) acc_reg <= acc_sum;
                    if (avg_load)     avg_reg <= acc_shift[ADC_W-1:0];
                end
            end

            assign set_hit = do_dac && (data[14] == 1'(gi));

`ifdef PDH_RAMP_EN
            logic [13:0]   step_reg;
            logic          en_reg, down_reg, move, over, under;
            logic [RW-1:0] cur_ext, step_ext, up_sum, dn_diff;

            assign cur_ext  = RW'(dac_reg);
            assign step_ext = RW'(step_reg);
            assign up_sum   = cur_ext + step_ext;
            assign dn_diff  = cur_ext - step_ext;
            assign over     = up_sum > RW'(DAC_MAX);
            assign under    = step_ext > cur_ext;
            assign move     = ramp_tick && en_reg && (step_reg != '0);

            // A SET_DAC on this channel overrides the ramp move in the same cycle.
            always_ff @(posedge clk) begin
                if (rst_i) begin
                    dac_reg  <= DAC_MID;
                    wrt_reg  <= 1'b0;
                    step_reg <= '0;
                    en_reg   <= 1'b0;
                    down_reg <= 1'b0;
                end else begin
                    wrt_reg <= set_hit | move;
                    if (set_hit) begin
                        dac_reg <= data[DAC_W-1:0];
                    end else if (move) begin
                        if (!down_reg) dac_reg <= over ? DAC_MAX : up_sum[DAC_W-1:0];
                        else           dac_reg <= under ? '0 : dn_diff[DAC_W-1:0];
                    end
                    if (do_ramp_en) begin
                        en_reg   <= data[gi];
                        down_reg <= 1'b0;
                    end else if (move && !set_hit) begin
                        if (!down_reg && over)     down_reg <= 1'b1;
                        else if (down_reg && under) down_reg <= 1'b0;
                    end
                    if (do_step && (data[14] == 1'(gi))) step_reg <= data[13:0];
                end
            end

            assign step_code[gi] = step_reg;
            assign en_bits[gi]   = en_reg;
            assign down_bits[gi] = down_reg;
`else
            always_ff @(posedge clk) begin
                if (rst_i) begin
                    dac_reg <= DAC_MID;
                    wrt_reg <= 1'b0;
                end else begin
                    wrt_reg <= set_hit;
                    if (set_hit) dac_reg <= data[DAC_W-1:0];
                end
            end
`endif

            assign dac_code[gi] = dac_reg;
            assign wrt_bits[gi] = wrt_reg;
            assign dac_pad[gi]  = 14'(dac_reg);
            assign adc_pad[gi]  = 14'(adc_reg[gi]);
            assign avg_pad[gi]  = 14'(avg_reg);
        end
    endgenerate

    logic [31:0] status_next, status_reg;

    // Layout follows whichever cmd is currently on the registered word, strobed or not.
    always_comb begin
        status_next = '0;
        case (cmd)
            CMD_SET_LED: status_next = {cmd, 20'd0, led_reg};
            CMD_SET_DAC: status_next = {cmd, dac_pad[1], dac_pad[0]};
            CMD_GET_ADC: status_next = {cmd, adc_pad[1], adc_pad[0]};
            CMD_AVG_ADC: status_next = busy_o ? {cmd, 28'd0} : {cmd, avg_pad[1], avg_pad[0]};
`ifdef PDH_RAMP_EN
            CMD_SET_RAMP_STEP: status_next = {cmd, step_code[1], step_code[0]};
            CMD_SET_RAMP_EN:   status_next = {cmd, 24'd0, down_bits, en_bits};
`endif
            default: status_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) status_reg <= '0;
        else       status_reg <= status_next;
    end

    assign led_o     = led_reg;
    assign dac_a_o   = dac_code[0];
    assign dac_b_o   = dac_code[1];
    assign dac_wrt_o = wrt_bits;
    assign status_o  = status_reg;
endmodule

// File: tb/tb_pdh_cmd_engine.sv
// Randomised self-checking bench for pdh_cmd_engine against a behavioural reference model.
`timescale 1ns/1ps
module tb_pdh_cmd_engine;
    localparam int AW = 14;
    localparam int DW = 14;
    localparam int AL = 4;
    localparam int RD = 2;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [31:0]   cmd_word_i = '0;
    logic [AW-1:0] adc_a_i = '0;
    logic [AW-1:0] adc_b_i = '0;
    logic [7:0]    led_o;
    logic [DW-1:0] dac_a_o, dac_b_o;
    logic [1:0]    dac_wrt_o;
    logic          busy_o;
    logic [31:0]   status_o;

    pdh_cmd_engine #(
        .ADC_DATA_WIDTH(AW), .DAC_DATA_WIDTH(DW), .AVG_LOG2(AL), .RAMP_DIV_LOG2(RD)
    ) dut (
        .clk(clk), .rst_i(rst_i), .cmd_word_i(cmd_word_i),
        .adc_a_i(adc_a_i), .adc_b_i(adc_b_i), .led_o(led_o),
        .dac_a_o(dac_a_o), .dac_b_o(dac_b_o), .dac_wrt_o(dac_wrt_o),
        .busy_o(busy_o), .status_o(status_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_word is the command word as seen one clock after the pins.
    logic [31:0] m_word;
    bit          m_prev;
    logic [7:0]  m_led;
    int          m_dac[2];
    bit          m_wrt[2];
    int          m_adc[2];
    int          m_left;
    int          m_sum[2];
    int          m_avg[2];
    logic [31:0] m_status;
`ifdef PDH_RAMP_EN
    int m_step[2];
    bit m_en[2];
    bit m_down[2];
    int m_since;
    int ramp_seen[$];
`endif

    function automatic int sx(input int v);
        return (v >= (1 << (AW - 1))) ? v - (1 << AW) : v;
    endfunction

    function automatic logic [31:0] model_status();
        logic [3:0] c;
        c = m_word[29:26];
        case (c)
            4'd1: return {c, 20'd0, m_led};
            4'd2: return {c, 14'(m_dac[1]), 14'(m_dac[0])};
            4'd4: return {c, 14'(m_adc[1]), 14'(m_adc[0])};
            4'd6: return (m_left > 0) ? {c, 28'd0} : {c, 14'(m_avg[1]), 14'(m_avg[0])};
`ifdef PDH_RAMP_EN
            4'd3: return {c, 14'(m_step[1]), 14'(m_step[0])};
            4'd5: return {c, 24'd0, m_down[1], m_down[0], m_en[1], m_en[0]};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_word = '0; m_prev = 0; m_led = '0; m_left = 0; m_status = '0;
        for (int k = 0; k < 2; k++) begin
            m_dac[k] = 1 << (DW - 1); m_wrt[k] = 0; m_adc[k] = 0; m_sum[k] = 0; m_avg[k] = 0;
`ifdef PDH_RAMP_EN
            m_step[k] = 0; m_en[k] = 0; m_down[k] = 0;
`endif
        end
`ifdef PDH_RAMP_EN
        m_since = 0;
`endif
    endtask

    task automatic model_edge(input logic r, input logic [31:0] w, input int a, input int b);
        logic [31:0] st;
        logic [3:0]  c;
        logic [25:0] d;
        bit          fire;
        int          ch;
`ifdef PDH_RAMP_EN
        bit          tick;
`endif
        if (r) begin
            model_reset();
            return;
        end
        st   = model_status();
        c    = m_word[29:26];
        d    = m_word[25:0];
        fire = m_word[30] && !m_prev;
        ch   = int'(d[14]);
        if (m_left > 0) begin
            for (int k = 0; k < 2; k++) m_sum[k] += sx(m_adc[k]);
            m_left--;
            if (m_left == 0)
                for (int k = 0; k < 2; k++) m_avg[k] = (m_sum[k] >>> AL) & ((1 << AW) - 1);
        end else if (fire && c == 4'd6) begin
            m_left = 1 << AL;
            for (int k = 0; k < 2; k++) m_sum[k] = 0;
        end
`ifdef PDH_RAMP_EN
        tick = (m_since % (1 << RD)) == ((1 << RD) - 1);
        m_since++;
`endif
        for (int k = 0; k < 2; k++) begin
            m_wrt[k] = 0;
            if (fire && c == 4'd2 && ch == k) begin
                m_dac[k] = int'(d[DW-1:0]);
                m_wrt[k] = 1;
            end
`ifdef PDH_RAMP_EN
            else if (tick && m_en[k] && m_step[k] != 0) begin
                m_wrt[k] = 1;
                if (!m_down[k]) begin
                    if (m_dac[k] + m_step[k] > DMAX) begin m_dac[k] = DMAX; m_down[k] = 1; end
                    else m_dac[k] += m_step[k];
                end else begin
                    if (m_step[k] > m_dac[k]) begin m_dac[k] = 0; m_down[k] = 0; end
                    else m_dac[k] -= m_step[k];
                end
            end
`endif
        end
`ifdef PDH_RAMP_EN
        if (fire && c == 4'd3) m_step[ch] = int'(d[13:0]);
        if (fire && c == 4'd5) begin
            m_en[0] = d[0]; m_en[1] = d[1]; m_down[0] = 0; m_down[1] = 0; m_since = 0;
        end
`endif
        if (fire && c == 4'd1) m_led = d[7:0];
        m_adc[0] = a; m_adc[1] = b;
        m_prev   = m_word[30];
        m_word   = w;
        m_status = st;
    endtask

    int adc_mode = 0;
    int adc_cnt = 0;
    int wrt_cnt[2];
    int busy_cnt = 0;
    int txn = 0;

    task automatic cycle(input logic r, input logic [31:0] w);
        int a, b;
        if (adc_mode == 1) begin
            a = 'h3FFD; b = adc_cnt % 16;
        end else if (adc_mode == 2) begin
            a = $urandom_range(0, 1) ? 'h1FFF : 'h2000;
            b = $urandom_range(0, 1) ? 'h3FFF : 'h0000;
        end else begin
            a = $urandom_range(0, (1 << AW) - 1);
            b = $urandom_range(0, (1 << AW) - 1);
        end
        adc_cnt++;
        rst_i = r; cmd_word_i = w; adc_a_i = AW'(a); adc_b_i = AW'(b);
        @(posedge clk);
        model_edge(r, w, a, b);
        #1;
        check_eq("led", led_o, m_led);
        check_eq("dac_a", dac_a_o, m_dac[0]);
        check_eq("dac_b", dac_b_o, m_dac[1]);
        check_eq("dac_wrt", dac_wrt_o, {m_wrt[1], m_wrt[0]});
        check_eq("busy", busy_o, (m_left > 0));
        check_eq("status", status_o, m_status);
        wrt_cnt[0] += dac_wrt_o[0];
        wrt_cnt[1] += dac_wrt_o[1];
        busy_cnt   += busy_o;
`ifdef PDH_RAMP_EN
        if (dac_wrt_o[0]) ramp_seen.push_back(int'(dac_a_o));
`endif
    endtask

    task automatic issue(input int c, input int d, input int hold, input int gap);
        logic [31:0] w;
        w = {1'b0, 1'b0, 4'(c), 26'(d)};
        w[31] = 1'($urandom_range(0, 1));
        txn++;
        $display("txn %0d: cmd %0d data 0x%07h hold %0d gap %0d", txn, c, 26'(d), hold, gap);
        w[30] = 1'b1;
        repeat (hold) cycle(1'b0, w);
        w[30] = 1'b0;
        repeat (gap) cycle(1'b0, w);
    endtask

    task automatic idle(input int n, input int c);
        repeat (n) cycle(1'b0, {2'b00, 4'(c), 26'd0});
    endtask

    initial begin
`ifdef PDH_RAMP_EN
        int exp_ramp[4] = '{'h3000, 'h3FFF, 'h2FFF, 'h1FFF};
`endif
        model_reset();
        repeat (3) cycle(1'b1, 32'd0);
        check_eq("rst_led", led_o, 32'h0);
        check_eq("rst_dac_a", dac_a_o, 32'h2000);
        check_eq("rst_dac_b", dac_b_o, 32'h2000);
        check_eq("rst_wrt", dac_wrt_o, 32'h0);
        check_eq("rst_busy", busy_o, 32'h0);
        check_eq("rst_status", status_o, 32'h0);

        issue(1, 'hA5, 5, 3);
        check_eq("set_led", led_o, 32'hA5);
        check_eq("set_led_status", status_o, 32'h100000A5);

        wrt_cnt = '{0, 0};
        issue(2, 'h5234, 1, 3);
        check_eq("set_dac_b", dac_b_o, 32'h1234);
        check_eq("set_dac_a_kept", dac_a_o, 32'h2000);
        check_eq("wrt_b_pulses", wrt_cnt[1], 1);
        check_eq("wrt_a_pulses", wrt_cnt[0], 0);
        check_eq("set_dac_status", status_o, 32'h248D2000);

        adc_mode = 1;
        busy_cnt = 0;
        issue(6, 0, 1, 5);
        check_eq("avg_busy_mid", busy_o, 32'h1);
        issue(6, 0, 2, 2);
        idle(20, 6);
        check_eq("avg_busy_cycles", busy_cnt, 16);
        check_eq("avg_busy_end", busy_o, 32'h0);
        check_eq("avg_status", status_o, 32'h6001FFFD);
        adc_mode = 0;

`ifdef PDH_RAMP_EN
        issue(3, 'h1000, 1, 2);
        ramp_seen.delete();
        issue(5, 1, 1, 17);
        issue(5, 0, 1, 3);
        check_eq("ramp_pulses", ramp_seen.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("ramp_step%0d", i),
                     (i < ramp_seen.size()) ? ramp_seen[i] : -1, exp_ramp[i]);
        issue(5, 1, 1, 2);
`else
        wrt_cnt = '{0, 0};
        issue(5, 1, 1, 20);
        check_eq("ramp_off_status", status_o, 32'h0);
        check_eq("ramp_off_wrt", wrt_cnt[0] + wrt_cnt[1], 0);
        check_eq("ramp_off_dac_a", dac_a_o, 32'h2000);
`endif

        issue(6, 0, 1, 5);
        cycle(1'b1, 32'd0);
        check_eq("mid_rst_led", led_o, 32'h0);
        check_eq("mid_rst_dac_a", dac_a_o, 32'h2000);
        check_eq("mid_rst_dac_b", dac_b_o, 32'h2000);
        check_eq("mid_rst_wrt", dac_wrt_o, 32'h0);
        check_eq("mid_rst_busy", busy_o, 32'h0);
        check_eq("mid_rst_status", status_o, 32'h0);
        wrt_cnt = '{0, 0};
        idle(12, 2);
        check_eq("post_rst_wrt", wrt_cnt[0] + wrt_cnt[1], 0);
        check_eq("post_rst_dac_a", dac_a_o, 32'h2000);

        for (int t = 0; t < 160; t++) begin
            int sel, c, d;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                cycle(1'b1, 32'd0);
            end else begin
                c = (sel < 17) ? (sel % 8) : $urandom_range(8, 15);
                d = $urandom_range(0, (1 << 26) - 1);
                adc_mode = $urandom_range(0, 2);
                issue(c, d, $urandom_range(1, 4), $urandom_range(1, 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
